// File: rtl/ofifo.sv
// ofifo - output FIFO bank behind the accumulate + ReLU stage.
//
// Each column has its own FIFO with its own write enable, because columns
// can finish on different cycles. A row is presented only when every column
// holds at least one entry, and a pop removes that row from all columns at once.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   in           column k data at [(k+1)*bw-1 : k*bw]
//   wr           per-column write enable
//   rd           pop one row from all columns
//   out          head entry of each column (show-ahead), zero when !o_valid
//   o_valid      every column non-empty
//   o_full       any column full
//   o_ready      ~o_full
//   o_overflow   sticky: a write hit a full column and was dropped
//   o_underflow  sticky: rd seen while o_valid low
module ofifo #(
   parameter int col   = 8,
   parameter int bw    = 16,
   parameter int depth = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [bw*col-1:0] in,
   input  logic [col-1:0]    wr,
   input  logic              rd,
   output logic [bw*col-1:0] out,
   output logic              o_valid,
   output logic              o_full,
   output logic              o_ready,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [col-1:0] w_nempty;
   logic [col-1:0] w_full;
   logic [col-1:0] w_wr_ok;
   logic           w_pop;

   // o_valid comes from registered counts only, so the pop decision
   // has no combinational dependence on wr or in.
   assign w_pop = rd & o_valid;

   for (genvar k = 0; k < col; k++) begin : g_col
      logic [bw-1:0] r_mem [depth];
      logic [AW-1:0] r_wptr;
      logic [AW-1:0] r_rptr;
      logic [CW-1:0] r_cnt;

      // Fullness uses the pre-edge count: a pop on the same edge does
      // not make room for the write.
      assign w_full[k]   = (r_cnt == CW'(depth));
      assign w_nempty[k] = (r_cnt != '0);
      assign w_wr_ok[k]  = wr[k] & ~w_full[k];

      // Storage is not reset; the pointers and counts define what is live.
      always_ff @(posedge clk) begin
         if (w_wr_ok[k]) r_mem[r_wptr] <= in[k*bw +: bw];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_wr_ok[k]) r_wptr <= r_wptr + AW'(1);
            if (w_pop)      r_rptr <= r_rptr + AW'(1);
            r_cnt <= r_cnt + CW'(w_wr_ok[k]) - CW'(w_pop);
         end
      end

      assign out[k*bw +: bw] = o_valid ? r_mem[r_rptr] : '0;
   end

   assign o_valid = &w_nempty;
   assign o_full  = |w_full;
   assign o_ready = ~o_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (|(wr & w_full)) o_overflow  <= 1'b1;
         if (rd & ~o_valid)  o_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo - directed plus randomized bench for ofifo.
// A queue per column serves as the reference; all outputs are compared
// against it one time unit after every rising edge.
module tb_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 64;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [127:0]   in = '0;
   logic [7:0]     wr = '0;
   logic           rd = 1'b0;
   logic [127:0]   out;
   logic           o_valid, o_full, o_ready, o_overflow, o_underflow;

   ofifo #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
      .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
      .o_overflow(o_overflow), .o_underflow(o_underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] q [COL][$];
   bit          m_ovf, m_udf;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_valid();
      for (int k = 0; k < COL; k++) if (q[k].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_full();
      for (int k = 0; k < COL; k++) if (q[k].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [127:0] m_out();
      logic [127:0] r;
      r = '0;
      if (m_valid()) for (int k = 0; k < COL; k++) r[k*16 +: 16] = q[k][0];
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < COL; k++) q[k].delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // Reference behaviour at one rising edge, decided from pre-edge state.
   task automatic model_edge(input logic [7:0] w, input logic [127:0] d, input logic r);
      bit v, acc;
      v = m_valid();
      if (r && !v) m_udf = 1'b1;
      for (int k = 0; k < COL; k++) begin
         acc = w[k] && (q[k].size() < DEPTH);
         if (w[k] && !acc) m_ovf = 1'b1;
         if (r && v) void'(q[k].pop_front());
         if (acc) q[k].push_back(d[k*16 +: 16]);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, o_valid, m_valid());
      chk({tag, ".full"}, o_full, m_full());
      chk({tag, ".ready"}, o_ready, !m_full());
      chk({tag, ".out"}, out, m_out());
      chk({tag, ".ovf"}, o_overflow, m_ovf);
      chk({tag, ".udf"}, o_underflow, m_udf);
   endtask

   task automatic step(input string tag, input logic [7:0] w, input logic [127:0] d, input logic r);
      wr = w; in = d; rd = r;
      @(posedge clk);
      model_edge(w, d, r);
      #1;
      check_all(tag);
   endtask

   function automatic logic [127:0] row_of(input int base);
      logic [127:0] r;
      for (int k = 0; k < COL; k++) r[k*16 +: 16] = 16'(base * 8 + k);
      return r;
   endfunction

   // Asynchronous reset applied off the clock edge; outputs must clear at once.
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_clear();
      check_all(tag);
      @(negedge clk);
      reset = 1'b0;
      wr = '0; rd = 1'b0;
   endtask

   logic [127:0] exp_row;
   logic [127:0] da, db;

   initial begin
      model_clear();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // 1: one full row, then pop it.
      for (int k = 0; k < COL; k++) exp_row[k*16 +: 16] = 16'(k + 1);
      step("row1", 8'hFF, exp_row, 1'b0);
      chk("row1.const", out, exp_row);
      step("row1pop", 8'h00, '0, 1'b1);
      chk("row1pop.zero", out, '0);

      // 2: staggered column writes.
      da = {8{16'hAAAA}};
      db = {8{16'hBBBB}};
      step("stagA", 8'h0F, da, 1'b0);
      chk("stagA.nv", o_valid, 1'b0);
      step("stagB", 8'hF0, db, 1'b0);
      chk("stagB.row", out, {{4{16'hBBBB}}, {4{16'hAAAA}}});
      step("stagpop", 8'h00, '0, 1'b1);

      // 3: fill column 0 alone, overflow it, then fill the rest and drain.
      for (int i = 0; i < DEPTH; i++) step("fill0", 8'h01, 128'(i), 1'b0);
      chk("fill0.full", o_full, 1'b1);
      chk("fill0.ready", o_ready, 1'b0);
      step("ovf", 8'h01, 128'hDEAD, 1'b0);
      chk("ovf.flag", o_overflow, 1'b1);
      for (int i = 0; i < DEPTH; i++) step("fillrest", 8'hFE, row_of(i), 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain.col0", out[15:0], 16'(i));
         step("drain", 8'h00, '0, 1'b1);
      end
      chk("drain.empty", o_valid, 1'b0);

      // 4: steady push/pop at depth 3 across pointer wrap.
      for (int i = 0; i < 3; i++) step("pre3", 8'hFF, row_of(i), 1'b0);
      for (int i = 3; i < 203; i++) step("pushpop", 8'hFF, row_of(i), 1'b1);
      for (int i = 0; i < 3; i++) step("post3", 8'h00, '0, 1'b1);

      // 5: underflow on empty, then normal traffic.
      step("udf", 8'h00, '0, 1'b1);
      chk("udf.flag", o_underflow, 1'b1);
      step("udfw", 8'hFF, row_of(77), 1'b0);
      chk("udfw.row", out, row_of(77));
      step("udfr", 8'h00, '0, 1'b1);

      // 6: reset mid-stream with 10 rows stored.
      for (int i = 0; i < 10; i++) step("ten", 8'hFF, row_of(300 + i), 1'b0);
      async_reset("midrst");
      step("postrst", 8'hFF, row_of(500), 1'b0);
      chk("postrst.row", out, row_of(500));

      // 7: random traffic, fill-biased phase then drain-biased phase.
      for (int i = 0; i < 300; i++)
         step("rndfill", 8'($urandom) | 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 9) == 0);
      for (int i = 0; i < 300; i++)
         step("rnddrain", 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 9) < 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
